// File: rtl/ucore_ackq_rd_if.sv
// Ack-queue bus bundle: ucore push side, host register-read side and status.
// master drives the pushes and reads; slave is the queue itself.
interface ucore_ackq_rd_if #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] ack_data;
  logic              ack_vld;
  logic              ack_rdy;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_vld;
  logic              rd_empty;
  logic [OCC_W-1:0]  occupancy;
  logic              full;
  logic [CNT_W-1:0]  err_cnt;
  logic              err_clr;

  modport master (
    output ack_data, ack_vld, rd_req, err_clr,
    input  ack_rdy, rd_data, rd_data_vld, rd_empty, occupancy, full, err_cnt
  );

  modport slave (
    input  ack_data, ack_vld, rd_req, err_clr,
    output ack_rdy, rd_data, rd_data_vld, rd_empty, occupancy, full, err_cnt
  );
endinterface

// File: rtl/ucore_ackq_rd.sv
// Ack queue between ucore firmware pushes and host register reads.
// Each read pops one word; a read of an empty queue returns RD_ERR and bumps err_cnt.
module ucore_ackq_rd #(
  parameter int unsigned        DEPTH  = 64,
  parameter int unsigned        DATA_W = 32,
  parameter logic [DATA_W-1:0]  RD_ERR = DATA_W'(32'hdeadc0de),
  parameter int unsigned        CNT_W  = 16
) (
  input  logic           clk,
  input  logic           a_rst_n,
  ucore_ackq_rd_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_occ;
  logic              r_full;
  logic              r_ack_rdy;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_vld;
  logic              r_rd_empty;
  logic [CNT_W-1:0]  r_err_cnt;

  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_rd_err;
  logic [PW-1:0]     w_occ_nxt;

  // Push/pop qualified on registered state only, so ack_rdy never depends on rd_req.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_push   = bus.ack_vld && r_ack_rdy;
  assign w_pop    = bus.rd_req && !w_empty;
  assign w_rd_err = bus.rd_req && w_empty;

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_push && !w_pop) begin
      w_occ_nxt = r_occ + PW'(1);
    end else if (!w_push && w_pop) begin
      w_occ_nxt = r_occ - PW'(1);
    end
  end

  // Storage needs no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.ack_data;
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      r_full    <= 1'b0;
      r_ack_rdy <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_occ     <= w_occ_nxt;
      r_full    <= (w_occ_nxt == PW'(DEPTH));
      r_ack_rdy <= (w_occ_nxt != PW'(DEPTH));
    end
  end

  // Read result path; rd_data holds between reads.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_rd_data  <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_empty <= 1'b0;
    end else begin
      r_rd_vld <= bus.rd_req;
      if (w_pop) begin
        r_rd_data  <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_empty <= 1'b0;
      end else if (w_rd_err) begin
        r_rd_data  <= RD_ERR;
        r_rd_empty <= 1'b1;
      end
    end
  end

  // Saturating empty-read counter; a clear beats a same-cycle empty read.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_err_cnt <= '0;
    end else if (bus.err_clr) begin
      r_err_cnt <= '0;
    end else if (w_rd_err && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign bus.ack_rdy     = r_ack_rdy;
  assign bus.rd_data     = r_rd_data;
  assign bus.rd_data_vld = r_rd_vld;
  assign bus.rd_empty    = r_rd_empty;
  assign bus.occupancy   = r_occ;
  assign bus.full        = r_full;
  assign bus.err_cnt     = r_err_cnt;
endmodule

// File: tb/tb_ucore_ackq_rd.sv
// Scoreboard bench for ucore_ackq_rd: a reference queue predicts each read result,
// and a negedge monitor pops and compares whenever rd_data_vld is seen.
module tb_ucore_ackq_rd;
  localparam int unsigned DEPTH  = 64;
  localparam logic [31:0] RD_ERR = 32'hdeadc0de;

  logic clk;
  logic a_rst_n;

  ucore_ackq_rd_if #(.DEPTH(DEPTH), .DATA_W(32), .CNT_W(16)) m ();
  ucore_ackq_rd_if #(.DEPTH(4), .DATA_W(32), .CNT_W(4))      m2 ();

  ucore_ackq_rd #(.DEPTH(DEPTH), .DATA_W(32), .RD_ERR(RD_ERR), .CNT_W(16)) u_dut (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .bus     (m)
  );

  ucore_ackq_rd #(.DEPTH(4), .DATA_W(32), .RD_ERR(RD_ERR), .CNT_W(4)) u_dut_sat (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .bus     (m2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] model [$];
  logic [32:0] exp_q [$];
  logic [15:0] err_model;
  logic        req_s;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Request seen at a clock edge; rd_data_vld must mirror it one cycle later.
  always @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) req_s <= 1'b0;
    else          req_s <= m.rd_req;
  end

  always @(negedge clk) begin
    if (a_rst_n) begin
      chk("rd_vld", 64'(m.rd_data_vld), 64'(req_s));
      if (m.rd_data_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("sb_extra", 64'(1), 64'(0));
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("rd_data", 64'(m.rd_data), 64'(e[31:0]));
          chk("rd_empty", 64'(m.rd_empty), 64'(e[32]));
        end
      end
    end
  end

  // One clock cycle of stimulus, entered and left at posedge+1.
  task automatic cyc(input logic push, input logic [31:0] d, input logic rd, input logic clr);
    logic acc;
    chk("ack_rdy", 64'(m.ack_rdy), 64'(model.size() < DEPTH));
    acc = push && (model.size() < DEPTH);
    if (rd) begin
      if (model.size() == 0) begin
        exp_q.push_back({1'b1, RD_ERR});
        if (err_model != 16'hffff) err_model = err_model + 16'd1;
      end else begin
        exp_q.push_back({1'b0, model.pop_front()});
      end
    end
    if (clr) err_model = 16'd0;
    if (acc) model.push_back(d);
    m.ack_vld  = push;
    m.ack_data = d;
    m.rd_req   = rd;
    m.err_clr  = clr;
    @(posedge clk);
    #1;
    m.ack_vld = 1'b0;
    m.rd_req  = 1'b0;
    m.err_clr = 1'b0;
    chk("occupancy", 64'(m.occupancy), 64'(model.size()));
    chk("full", 64'(m.full), 64'(model.size() == DEPTH));
    chk("err_cnt", 64'(m.err_cnt), 64'(err_model));
  endtask

  task automatic chk_reset_state();
    chk("rst_occ", 64'(m.occupancy), 64'(0));
    chk("rst_full", 64'(m.full), 64'(0));
    chk("rst_ack_rdy", 64'(m.ack_rdy), 64'(1));
    chk("rst_rd_data", 64'(m.rd_data), 64'(0));
    chk("rst_rd_vld", 64'(m.rd_data_vld), 64'(0));
    chk("rst_rd_empty", 64'(m.rd_empty), 64'(0));
    chk("rst_err_cnt", 64'(m.err_cnt), 64'(0));
  endtask

  initial begin
    a_rst_n    = 1'b0;
    m.ack_data = '0;
    m.ack_vld  = 1'b0;
    m.rd_req   = 1'b0;
    m.err_clr  = 1'b0;
    m2.ack_data = '0;
    m2.ack_vld  = 1'b0;
    m2.rd_req   = 1'b0;
    m2.err_clr  = 1'b0;
    err_model  = 16'd0;
    #22;
    a_rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_state();

    // Empty read after reset
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);

    // Three pushes, three back-to-back reads
    cyc(1'b1, 32'h11, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b0, 1'b0);
    cyc(1'b1, 32'h33, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);

    // Fill to full, hold the 65th word, then drain across the wrap
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'(DEPTH), 1'b1, 1'b0);
    cyc(1'b1, 32'(DEPTH), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);

    // Push and read together on an empty queue
    cyc(1'b1, 32'ha5, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);

    // Steady state at occupancy 5
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset in the middle of a drain
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    #2;
    a_rst_n = 1'b0;
    #1;
    chk("mid_rst_occ", 64'(m.occupancy), 64'(0));
    chk("mid_rst_vld", 64'(m.rd_data_vld), 64'(0));
    model.delete();
    exp_q.delete();
    err_model = 16'd0;
    #3;
    a_rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_state();
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);

    // Counter saturation and clear priority on a 4-bit counter instance
    m2.rd_req = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
    end
    m2.rd_req = 1'b0;
    chk("sat_cnt_e", 64'(m2.err_cnt), 64'(4'he));
    chk("sat_rd_data", 64'(m2.rd_data), 64'(RD_ERR));
    chk("sat_rd_empty", 64'(m2.rd_empty), 64'(1));
    m2.rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    m2.rd_req = 1'b0;
    chk("sat_cnt_f", 64'(m2.err_cnt), 64'(4'hf));
    m2.rd_req  = 1'b1;
    m2.err_clr = 1'b1;
    @(posedge clk);
    #1;
    m2.rd_req  = 1'b0;
    m2.err_clr = 1'b0;
    chk("clr_wins", 64'(m2.err_cnt), 64'(0));

    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("sb_left", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
